// File: rtl/snake_body_renderer_if.sv
// Control/pixel bundle between a game controller (master) and the snake engine (slave).
interface snake_body_renderer_if #(parameter int LW = 5);
   logic          init;
   logic [7:0]    start_x;
   logic [6:0]    start_y;
   logic [LW-1:0] init_len;
   logic          tick;
   logic [1:0]    dir;
   logic          grow;
   logic [2:0]    body_colour;
   logic [2:0]    bg_colour;
   logic [7:0]    vga_x;
   logic [6:0]    vga_y;
   logic [2:0]    vga_colour;
   logic          plot;
   logic          busy;
   logic          done;
   logic          collide;
   logic [LW-1:0] len;

   modport master (
      output init, start_x, start_y, init_len, tick, dir, grow, body_colour, bg_colour,
      input  vga_x, vga_y, vga_colour, plot, busy, done, collide, len
   );
   modport slave (
      input  init, start_x, start_y, init_len, tick, dir, grow, body_colour, bg_colour,
      output vga_x, vga_y, vga_colour, plot, busy, done, collide, len
   );
endinterface

// File: rtl/snake_body_renderer.sv
// Shift-register snake body drawn incrementally on the vga_adapter port; move takes 2*SEG*SEG+3 cycles
// (SEG*SEG+3 growing), ticks while busy are dropped. Define SNAKE_WRAP_EN for wrap-around instead of edge collision.
module snake_body_renderer #(
   parameter int MAX_LEN = 16,
   parameter int LW      = 5,
   parameter int SEG     = 10,
   parameter int XSCREEN = 160,
   parameter int YSCREEN = 120
) (
   input  logic CLOCK_50,
   input  logic Resetn,
   snake_body_renderer_if.slave bus
);
   localparam int IW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

   typedef enum logic [2:0] {IDLE, INIT_DRAW, CHECK, ERASE, SHIFT, DRAW, FINISH} state_t;
   state_t state, next_state;

   logic [7:0]    seg_x [MAX_LEN];
   logic [6:0]    seg_y [MAX_LEN];
   logic [LW-1:0] len_q, idx, tail, clamp_len;
   logic [1:0]    cur_dir, eff_dir;
   logic          grow_pend, grow_move, collide_q, edge_hit;
   logic [7:0]    nh_x, px, nx, base_x;
   logic [6:0]    nh_y, py, ny, base_y;
   logic [8:0]    nx9, ny9;
   logic          nedge, self_hit, last_px, seg_last, plot_i;
   logic [2:0]    colour_i;

   assign tail      = len_q - 1'b1;
   assign last_px   = (px == 8'(SEG - 1)) && (py == 7'(SEG - 1));
   assign seg_last  = (idx == tail);
   assign clamp_len = (bus.init_len < LW'(2)) ? LW'(2) :
                      (bus.init_len > LW'(MAX_LEN)) ? LW'(MAX_LEN) : bus.init_len;

   // Reversal requests keep the current heading.
   always_comb begin
      eff_dir = (bus.dir == ~cur_dir) ? cur_dir : bus.dir;
      nx9 = {1'b0, seg_x[0]};
      ny9 = {2'b00, seg_y[0]};
      case (eff_dir)
         2'b00:   nx9 = nx9 + 9'(SEG);
         2'b11:   nx9 = nx9 - 9'(SEG);
         2'b01:   ny9 = ny9 + 9'(SEG);
         default: ny9 = ny9 - 9'(SEG);
      endcase
`ifdef SNAKE_WRAP_EN
      nedge = 1'b0;
      if (nx9[8])                    nx = 8'(XSCREEN - SEG);
      else if (nx9 >= 9'(XSCREEN))   nx = 8'd0;
      else                           nx = nx9[7:0];
      if (ny9[8])                    ny = 7'(YSCREEN - SEG);
      else if (ny9 >= 9'(YSCREEN))   ny = 7'd0;
      else                           ny = ny9[6:0];
`else
      nedge = (nx9 > 9'(XSCREEN - SEG)) || (ny9 > 9'(YSCREEN - SEG));
      nx    = nx9[7:0];
      ny    = ny9[6:0];
`endif
   end

   // The tail square vacates during this move unless a grow is pending.
   always_comb begin
      self_hit = 1'b0;
      for (int i = 0; i < MAX_LEN; i++) begin
         if ((LW'(i) < len_q) && (grow_pend || (LW'(i) != tail)) &&
             (seg_x[i] == nh_x) && (seg_y[i] == nh_y))
            self_hit = 1'b1;
      end
   end

   always_ff @(posedge CLOCK_50) begin
      if (!Resetn) state <= IDLE;
      else         state <= next_state;
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE: begin
            if (bus.init)                                    next_state = INIT_DRAW;
            else if (bus.tick && (len_q != '0) && !collide_q) next_state = CHECK;
         end
         INIT_DRAW: if (last_px && seg_last) next_state = FINISH;
         CHECK: begin
            if (edge_hit || self_hit)                       next_state = FINISH;
            else if (grow_pend && (len_q < LW'(MAX_LEN)))   next_state = SHIFT;
            else                                            next_state = ERASE;
         end
         ERASE:   if (last_px) next_state = SHIFT;
         SHIFT:   next_state = DRAW;
         DRAW:    if (last_px) next_state = FINISH;
         FINISH:  next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   always_ff @(posedge CLOCK_50) begin
      if (!Resetn) begin
         len_q     <= '0;
         idx       <= '0;
         cur_dir   <= 2'b00;
         grow_pend <= 1'b0;
         grow_move <= 1'b0;
         collide_q <= 1'b0;
         edge_hit  <= 1'b0;
         nh_x      <= '0;
         nh_y      <= '0;
         px        <= '0;
         py        <= '0;
      end else begin
         if (bus.grow) grow_pend <= 1'b1;
         case (state)
            IDLE: begin
               px <= '0;
               py <= '0;
               if (bus.init) begin
                  for (int i = 0; i < MAX_LEN; i++) begin
                     seg_x[i] <= bus.start_x - 8'(i * SEG);
                     seg_y[i] <= bus.start_y;
                  end
                  len_q     <= clamp_len;
                  collide_q <= 1'b0;
                  cur_dir   <= 2'b00;
                  idx       <= '0;
               end else if (bus.tick && (len_q != '0) && !collide_q) begin
                  cur_dir  <= eff_dir;
                  nh_x     <= nx;
                  nh_y     <= ny;
                  edge_hit <= nedge;
               end
            end
            INIT_DRAW, ERASE, DRAW: begin
               if (px == 8'(SEG - 1)) begin
                  px <= '0;
                  py <= (py == 7'(SEG - 1)) ? 7'd0 : py + 7'd1;
               end else begin
                  px <= px + 8'd1;
               end
               if ((state == INIT_DRAW) && last_px) idx <= idx + 1'b1;
            end
            CHECK: begin
               if (edge_hit || self_hit) collide_q <= 1'b1;
               grow_move <= grow_pend && (len_q < LW'(MAX_LEN));
            end
            SHIFT: begin
               for (int i = MAX_LEN - 1; i > 0; i--) begin
                  seg_x[i] <= seg_x[i-1];
                  seg_y[i] <= seg_y[i-1];
               end
               seg_x[0]  <= nh_x;
               seg_y[0]  <= nh_y;
               if (grow_move) len_q <= len_q + 1'b1;
               grow_pend <= bus.grow;
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      plot_i   = 1'b0;
      colour_i = 3'd0;
      base_x   = seg_x[0];
      base_y   = seg_y[0];
      case (state)
         INIT_DRAW: begin
            plot_i   = 1'b1;
            colour_i = bus.body_colour;
            base_x   = seg_x[idx[IW-1:0]];
            base_y   = seg_y[idx[IW-1:0]];
         end
         ERASE: begin
            plot_i   = 1'b1;
            colour_i = bus.bg_colour;
            base_x   = seg_x[tail[IW-1:0]];
            base_y   = seg_y[tail[IW-1:0]];
         end
         DRAW: begin
            plot_i   = 1'b1;
            colour_i = bus.body_colour;
         end
         default: ;
      endcase
   end

   assign bus.plot       = plot_i;
   assign bus.vga_colour = colour_i;
   assign bus.vga_x      = plot_i ? base_x + px : 8'd0;
   assign bus.vga_y      = plot_i ? base_y + py : 7'd0;
   assign bus.busy       = (state != IDLE);
   assign bus.done       = (state == FINISH);
   assign bus.collide    = collide_q;
   assign bus.len        = len_q;
endmodule

// File: tb/tb_snake_body_renderer.sv
// Random and directed moves against a queue-based snake model that predicts every plotted pixel.
module tb_snake_body_renderer;
   localparam int MAX_LEN = 16;
   localparam int LW      = 5;
   localparam int SEG     = 2;
   localparam int XS      = 160;
   localparam int YS      = 120;
   localparam int BODY    = 5;
   localparam int BG      = 1;
`ifdef SNAKE_WRAP_EN
   localparam bit WRAP = 1'b1;
`else
   localparam bit WRAP = 1'b0;
`endif

   logic clk  = 1'b0;
   logic rstn = 1'b0;
   always #5 clk = ~clk;

   snake_body_renderer_if #(.LW(LW)) bus ();
   snake_body_renderer #(.MAX_LEN(MAX_LEN), .LW(LW), .SEG(SEG), .XSCREEN(XS), .YSCREEN(YS))
      dut (.CLOCK_50(clk), .Resetn(rstn), .bus(bus));

   int n_cmp = 0;
   int n_bad = 0;
   int bx[$];
   int by[$];
   int expq[$];
   int mdir;
   bit mgrow, mcol;
   int op_plots, first_pix, first_body, done_cnt, last_lat;

   function automatic int pix(input int x, input int y, input int c);
      return (x << 10) | (y << 3) | c;
   endfunction

   task automatic check(input string name, input int act, input int req);
      n_cmp++;
      if (act != req) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d", name, act, req);
      end
   endtask

   task automatic push_square(input int x, input int y, input int c);
      for (int yy = 0; yy < SEG; yy++)
         for (int xx = 0; xx < SEG; xx++)
            expq.push_back(pix(x + xx, y + yy, c));
   endtask

   task automatic clear_inputs();
      bus.tick = 1'b0;
      bus.init = 1'b0;
      bus.grow = 1'b0;
   endtask

   task automatic begin_op();
      op_plots   = 0;
      first_pix  = -1;
      first_body = -1;
      done_cnt   = 0;
      last_lat   = -1;
   endtask

   // Per-cycle monitor: every plotted pixel must be the next one the model predicted.
   task automatic step();
      int act;
      @(negedge clk);
      if (bus.plot) begin
         op_plots++;
         act = pix(int'(bus.vga_x), int'(bus.vga_y), int'(bus.vga_colour));
         if (op_plots == 1) first_pix = act;
         if (first_body < 0 && bus.vga_colour == 3'(BODY)) first_body = act;
         if (expq.size() == 0) check("unexpected plot", act, -1);
         else                  check("pixel", act, expq.pop_front());
      end
      if (bus.done) done_cnt++;
   endtask

   task automatic wait_done(input int exp_lat, input bit inject, input string name);
      int cyc, inj_at;
      bit seen;
      cyc    = 0;
      seen   = 1'b0;
      inj_at = inject ? int'($urandom_range(1, exp_lat - 1)) : -1;
      while (!seen && cyc < 200) begin
         step();
         cyc++;
         clear_inputs();
         if (bus.done) seen = 1'b1;
         else if (cyc == inj_at) begin
            bus.tick = 1'b1;
            bus.dir  = 2'($urandom_range(0, 3));
         end
      end
      last_lat = seen ? cyc : -1;
      check({name, " latency"}, last_lat, exp_lat);
      step();
      check({name, " busy after done"}, int'(bus.busy), 0);
      check({name, " done count"}, done_cnt, 1);
      check({name, " pixels left"}, expq.size(), 0);
      check({name, " len"}, int'(bus.len), bx.size());
      check({name, " collide"}, int'(bus.collide), int'(mcol));
   endtask

   task automatic wait_idle(input int n, input string name);
      for (int k = 0; k < n; k++) begin
         step();
         clear_inputs();
      end
      check({name, " no done"}, done_cnt, 0);
      check({name, " no plots"}, op_plots, 0);
   endtask

   task automatic do_init(input int sx, input int sy, input int l, input string name);
      int cl;
      cl = (l < 2) ? 2 : ((l > MAX_LEN) ? MAX_LEN : l);
      bx.delete();
      by.delete();
      for (int i = 0; i < cl; i++) begin
         bx.push_back((sx - i * SEG) & 255);
         by.push_back(sy);
      end
      mcol = 1'b0;
      mdir = 0;
      begin_op();
      for (int i = 0; i < cl; i++) push_square(bx[i], by[i], BODY);
      bus.init     = 1'b1;
      bus.start_x  = 8'(sx);
      bus.start_y  = 7'(sy);
      bus.init_len = LW'(l);
      wait_done(cl * SEG * SEG + 1, 1'b0, name);
   endtask

   task automatic do_move(input int d, input bit g, input bit inject, input string name);
      int e, nx, ny, lat;
      bit hit, growing;
      if (g) mgrow = 1'b1;
      begin_op();
      bus.tick = 1'b1;
      bus.dir  = 2'(d);
      bus.grow = g;
      if (bx.size() == 0 || mcol) begin
         wait_idle(12, name);
         return;
      end
      e    = (d == 3 - mdir) ? mdir : d;
      mdir = e;
      nx   = bx[0];
      ny   = by[0];
      case (e)
         0:       nx += SEG;
         3:       nx -= SEG;
         1:       ny += SEG;
         default: ny -= SEG;
      endcase
      hit = 1'b0;
      if (WRAP) begin
         if (nx < 0) nx = XS - SEG; else if (nx > XS - SEG) nx = 0;
         if (ny < 0) ny = YS - SEG; else if (ny > YS - SEG) ny = 0;
      end else begin
         hit = (nx < 0) || (nx > XS - SEG) || (ny < 0) || (ny > YS - SEG);
      end
      for (int i = 0; i < bx.size(); i++)
         if ((mgrow || i != bx.size() - 1) && bx[i] == nx && by[i] == ny) hit = 1'b1;
      if (hit) begin
         mcol = 1'b1;
         lat  = 2;
      end else begin
         growing = mgrow && (bx.size() < MAX_LEN);
         if (!growing) begin
            push_square(bx[$], by[$], BG);
            void'(bx.pop_back());
            void'(by.pop_back());
         end
         bx.push_front(nx);
         by.push_front(ny);
         mgrow = 1'b0;
         push_square(nx, ny, BODY);
         lat = growing ? SEG * SEG + 3 : 2 * SEG * SEG + 3;
      end
      wait_done(lat, inject, name);
   endtask

   task automatic grow_idle();
      begin_op();
      bus.grow = 1'b1;
      mgrow    = 1'b1;
      step();
      clear_inputs();
   endtask

   initial begin
      int sx, sy, l;
      clear_inputs();
      bus.dir         = 2'd0;
      bus.start_x     = 8'd0;
      bus.start_y     = 7'd0;
      bus.init_len    = '0;
      bus.body_colour = 3'(BODY);
      bus.bg_colour   = 3'(BG);
      mdir  = 0;
      mgrow = 1'b0;
      mcol  = 1'b0;
      begin_op();
      repeat (3) step();
      check("reset plot", int'(bus.plot), 0);
      check("reset busy", int'(bus.busy), 0);
      check("reset done", int'(bus.done), 0);
      check("reset len", int'(bus.len), 0);
      check("reset collide", int'(bus.collide), 0);
      rstn = 1'b1;
      do_move(0, 1'b0, 1'b0, "tick len0");

      do_init(20, 50, 3, "t1 init");
      check("t1 plots", op_plots, 12);
      check("t1 first", first_pix, pix(20, 50, BODY));
      check("t1 lat", last_lat, 13);
      check("t1 len", int'(bus.len), 3);

      do_move(0, 1'b0, 1'b0, "t2 right");
      check("t2 lat", last_lat, 11);
      check("t2 plots", op_plots, 8);
      check("t2 erase", first_pix, pix(16, 50, BG));
      check("t2 head", first_body, pix(22, 50, BODY));

      do_move(1, 1'b1, 1'b0, "t3 grow down");
      check("t3 lat", last_lat, 7);
      check("t3 plots", op_plots, 4);
      check("t3 head", first_pix, pix(22, 52, BODY));
      check("t3 len", int'(bus.len), 4);

      do_move(0, 1'b0, 1'b0, "t4a right");
      check("t4a head", first_body, pix(24, 52, BODY));
      do_move(3, 1'b0, 1'b1, "t4b reversal");
      check("t4b erase", first_pix, pix(20, 50, BG));
      check("t4b head", first_body, pix(26, 52, BODY));

      do_init(100, 20, 0, "clamp lo");
      check("clamp lo len", int'(bus.len), 2);
      do_init(100, 20, 31, "clamp hi");
      check("clamp hi len", int'(bus.len), MAX_LEN);
      do_move(0, 1'b1, 1'b0, "grow at max");
      check("grow at max lat", last_lat, 11);
      check("grow at max len", int'(bus.len), MAX_LEN);
      do_move(1, 1'b0, 1'b0, "self down");
      do_move(3, 1'b0, 1'b0, "self left");
      do_move(2, 1'b0, 1'b0, "self up");
      check("self lat", last_lat, 2);
      check("self plots", op_plots, 0);
      check("self collide", int'(bus.collide), 1);
      do_move(0, 1'b0, 1'b0, "frozen tick");

      do_init(158, 50, 3, "t5 init");
      do_move(0, 1'b0, 1'b0, "t5 edge");
`ifdef SNAKE_WRAP_EN
      check("t5 wrap head", first_body, pix(0, 50, BODY));
      check("t5 wrap collide", int'(bus.collide), 0);
`else
      check("t5 edge plots", op_plots, 0);
      check("t5 edge collide", int'(bus.collide), 1);
`endif
      do_move(1, 1'b0, 1'b0, "t5 after");

      do_init(40, 40, 4, "t6 init");
      begin_op();
      push_square(34, 40, BG);
      push_square(40, 42, BODY);
      bus.tick = 1'b1;
      bus.dir  = 2'd1;
      step();
      clear_inputs();
      repeat (6) step();
      check("t6 plots before reset", op_plots, 5);
      expq.delete();
      rstn = 1'b0;
      step();
      check("t6 rst plot", int'(bus.plot), 0);
      check("t6 rst busy", int'(bus.busy), 0);
      check("t6 rst len", int'(bus.len), 0);
      check("t6 rst collide", int'(bus.collide), 0);
      rstn = 1'b1;
      bx.delete();
      by.delete();
      mgrow = 1'b0;
      mcol  = 1'b0;
      mdir  = 0;
      do_move(0, 1'b0, 1'b0, "t6 tick after reset");
      do_init(60, 60, 5, "t6 reinit");
      do_move(1, 1'b0, 1'b0, "t6 move");

      for (int r = 0; r < 8; r++) begin
         l  = int'($urandom_range(2, MAX_LEN));
         sx = SEG * int'($urandom_range(l - 1, XS / SEG - 1));
         sy = SEG * int'($urandom_range(0, YS / SEG - 1));
         do_init(sx, sy, l, "rnd init");
         for (int m = 0; m < 50; m++) begin
            if ($urandom_range(0, 7) == 0) grow_idle();
            do_move(int'($urandom_range(0, 3)), $urandom_range(0, 3) == 0,
                    $urandom_range(0, 2) == 0, "rnd move");
            if (mcol) break;
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end
endmodule
